// File: rtl/ode_param_bank.sv
// Double-buffered ODE parameter bank: Avalon-MM shadows committed at step boundaries, step-strobe divider, timed solver reset.
// Read data returns one cycle after avs_read; the slave never stalls (no waitrequest).
module ode_param_bank #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 3,
    parameter int RATE_INIT = 0,
    parameter int RST_CYC   = 4
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [ADDR_W-1:0]          avs_address,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    input  logic                       avs_read,
    output logic [31:0]                avs_readdata,
    output logic                       avs_readdatavalid,
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       solver_clk_en,
    output logic                       solver_rst,
    output logic                       running
);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] A_RATE = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CH + 2);
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(NUM_CH + 3);
    localparam int                RC_W   = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SRST = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RC_W-1:0]     r_rst_cnt;
    logic [15:0]         r_cnt;
    logic [15:0]         r_rate;
    logic [31:0]         r_step;
    logic                r_pending;
    logic [31:0]         r_rdata;
    logic                r_rvld;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic [DATA_W-1:0]   r_active [NUM_CH];

    logic                w_wr_ctrl;
    logic                w_wr_rate;
    logic                w_commit;
    logic                w_srst_req;
    logic                w_run;
    logic                w_stop;
    logic                w_strobe;
    logic                w_srst_entry;
    logic                w_copy;
    logic [31:0]         w_rd_mux;
    logic                w_unused_wdata;

    assign w_wr_ctrl  = avs_write && (avs_address == A_CTRL);
    assign w_wr_rate  = avs_write && (avs_address == A_RATE);
    assign w_commit   = w_wr_ctrl && avs_writedata[0];
    assign w_srst_req = w_wr_ctrl && avs_writedata[1];
    assign w_run      = w_wr_ctrl && avs_writedata[2];
    assign w_stop     = w_wr_ctrl && avs_writedata[3];

    // Upper writedata bits beyond the widest register are intentionally dropped.
    assign w_unused_wdata = ^avs_writedata;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SRST_REQ outranks STOP/RUN; the reset window ignores all control pulses.
    always_comb begin
        w_state_nxt  = r_state;
        w_strobe     = 1'b0;
        w_srst_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_srst_req) begin
                    w_state_nxt  = S_SRST;
                    w_srst_entry = 1'b1;
                end else if (w_run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_SRST: begin
                if (r_rst_cnt == RC_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_strobe = (r_cnt >= r_rate);
                if (w_srst_req) begin
                    w_state_nxt  = S_SRST;
                    w_srst_entry = 1'b1;
                end else if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outside RUN a pending commit lands at once; inside RUN only on a step strobe.
    assign w_copy = r_pending && ((r_state != S_RUN) || w_strobe);

    always_comb begin
        w_rd_mux = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == ADDR_W'(i)) begin
                w_rd_mux = 32'($signed(r_shadow[i]));
            end
        end
        if (avs_address == A_RATE) begin
            w_rd_mux = {16'd0, r_rate};
        end else if (avs_address == A_STAT) begin
            w_rd_mux = {29'd0, solver_rst, running, r_pending};
        end else if (avs_address == A_STEP) begin
            w_rd_mux = r_step;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rst_cnt <= '0;
            r_cnt     <= 16'd0;
            r_rate    <= 16'(RATE_INIT);
            r_step    <= 32'd0;
            r_pending <= 1'b0;
            r_rdata   <= 32'd0;
            r_rvld    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_srst_entry) begin
                r_rst_cnt <= RC_W'(RST_CYC);
            end else if (r_state == S_SRST) begin
                r_rst_cnt <= r_rst_cnt - RC_W'(1);
            end

            if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && !w_strobe) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= 16'd0;
            end

            if (w_srst_entry) begin
                r_step <= 32'd0;
            end else if (w_strobe) begin
                r_step <= r_step + 32'd1;
            end

            if (w_wr_rate) begin
                r_rate <= avs_writedata[15:0];
            end

            // A COMMIT arriving while one is outstanding merges into the same copy.
            r_pending <= w_copy ? 1'b0 : (r_pending || w_commit);

            for (int i = 0; i < NUM_CH; i++) begin
                if (w_copy) begin
                    r_active[i] <= r_shadow[i];
                end
                if (avs_write && (avs_address == ADDR_W'(i))) begin
                    r_shadow[i] <= avs_writedata[DATA_W-1:0];
                end
            end

            r_rvld <= avs_read;
            if (avs_read) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvld;
    assign solver_clk_en     = w_strobe;
    assign solver_rst        = (r_state == S_SRST);
    assign running           = (r_state == S_RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_data[g*DATA_W +: DATA_W] = r_active[g];
    end

endmodule

// File: tb/tb_ode_param_bank.sv
// Bench for ode_param_bank: directed register-level scenarios checked against a cycle model and literal expectations.
module tb_ode_param_bank;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 18;
    localparam int ADDR_W    = 3;
    localparam int RATE_INIT = 0;
    localparam int RST_CYC   = 4;

    logic                     clk_clk = 1'b0;
    logic                     reset_reset;
    logic [ADDR_W-1:0]        avs_address;
    logic                     avs_write;
    logic [31:0]              avs_writedata;
    logic                     avs_read;
    logic [31:0]              avs_readdata;
    logic                     avs_readdatavalid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     solver_clk_en;
    logic                     solver_rst;
    logic                     running;

    ode_param_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .RATE_INIT(RATE_INIT), .RST_CYC(RST_CYC)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .ch_data(ch_data), .solver_clk_en(solver_clk_en),
        .solver_rst(solver_rst), .running(running)
    );

    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 solver reset, 2 run.
    int                 m_mode;
    int                 m_left;
    int                 m_since;
    int                 m_rate;
    logic [31:0]        m_step;
    logic [DATA_W-1:0]  m_shadow [NUM_CH];
    logic [DATA_W-1:0]  m_active [NUM_CH];
    bit                 m_pending;
    logic [31:0]        m_rdata;
    bit                 m_rvld;
    bit                 m_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0] cmp_exp;

    function automatic bit m_strobe();
        return (m_mode == 2) && (m_since >= m_rate);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a < NUM_CH) return {{(32-DATA_W){m_shadow[a][DATA_W-1]}}, m_shadow[a]};
        if (a == NUM_CH + 1) return 32'(m_rate);
        if (a == NUM_CH + 2) return {29'd0, m_mode == 1, m_mode == 2, m_pending};
        if (a == NUM_CH + 3) return m_step;
        return 32'd0;
    endfunction

    always @(posedge clk_clk) begin : model
        bit stb, cp, cmt, srq, run, stp;
        int a;
        if (reset_reset) begin
            m_mode = 0; m_left = 0; m_since = 0; m_rate = RATE_INIT; m_step = 0;
            m_pending = 0; m_rdata = 0; m_rvld = 0; m_valid = 1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
        end else begin
            a   = int'(avs_address);
            stb = m_strobe();
            cp  = m_pending && (m_mode != 2 || stb);
            cmt = avs_write && a == NUM_CH && avs_writedata[0];
            srq = avs_write && a == NUM_CH && avs_writedata[1];
            run = avs_write && a == NUM_CH && avs_writedata[2];
            stp = avs_write && a == NUM_CH && avs_writedata[3];
            if (avs_read) begin
                m_rdata = m_read(a);
                m_rvld  = 1;
            end else begin
                m_rvld = 0;
            end
            if (cp) for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
            m_pending = cp ? 1'b0 : (m_pending || cmt);
            if (stb) m_step = m_step + 1;
            case (m_mode)
                0: if (srq) begin m_mode = 1; m_left = RST_CYC; m_step = 0; end
                   else if (run) begin m_mode = 2; m_since = 0; end
                1: begin m_left--; if (m_left == 0) m_mode = 0; end
                default: if (srq) begin m_mode = 1; m_left = RST_CYC; m_step = 0; end
                   else if (stp) m_mode = 0;
                   else m_since = stb ? 0 : m_since + 1;
            endcase
            if (avs_write && a < NUM_CH) m_shadow[a] = avs_writedata[DATA_W-1:0];
            if (avs_write && a == NUM_CH + 1) m_rate = int'(avs_writedata[15:0]);
        end
    end

    always @(negedge clk_clk) begin
        if (m_valid) begin
            for (int i = 0; i < NUM_CH; i++) cmp_exp[i*DATA_W +: DATA_W] = m_active[i];
            chk("ch_data", ch_data, cmp_exp);
            chk("solver_clk_en", solver_clk_en, m_strobe());
            chk("solver_rst", solver_rst, m_mode == 1);
            chk("running", running, m_mode == 2);
            chk("readdatavalid", avs_readdatavalid, m_rvld);
            chk("readdata", avs_readdata, m_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = ADDR_W'(a); avs_writedata = d;
        cyc();
        avs_write = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = ADDR_W'(a);
        cyc();
        avs_read = 1'b0;
        chk("rvld_after_read", avs_readdatavalid, 1);
        d = avs_readdata;
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!solver_clk_en && n < 300) begin
            cyc();
            n++;
        end
        chk(name, solver_clk_en, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [NUM_CH*DATA_W-1:0] kept;
        int t, n, last, cnt;

        reset_reset = 1'b1; avs_address = '0; avs_write = 1'b0;
        avs_writedata = 32'd0; avs_read = 1'b0;
        cyc(); cyc();
        reset_reset = 1'b0;

        // Reset state
        chk("rst_ch_data", ch_data, 0);
        chk("rst_solver_rst", solver_rst, 0);
        chk("rst_running", running, 0);
        rd(5, d); chk("rst_rate", d, 32'd0);
        rd(7, d); chk("rst_step_cnt", d, 32'd0);

        // Idle commit with sign extension
        wr(0, 32'h0003FFFF);
        rd(0, d); chk("shadow0_sext", d, 32'hFFFFFFFF);
        wr(4, 32'h1);
        chk("ch0_before_copy", ch_data[17:0], 18'h0);
        rd(6, d); chk("status_pending", d, 32'd1);
        chk("ch0_committed", ch_data[17:0], 18'h3FFFF);
        rd(6, d); chk("status_cleared", d, 32'd0);

        // Divider period RATE=3 -> strobe every 4 cycles
        wr(5, 32'd3);
        wr(4, 32'h4);
        t = 1; n = 0; last = 0;
        for (int k = 0; k < 100; k++) begin
            if (solver_clk_en) begin
                n++;
                chk("pulse_gap", t - last, 4);
                last = t;
                if (n == 10) break;
            end
            cyc();
            t++;
        end
        chk("pulse_count", n, 10);
        wr(4, 32'h8);
        cnt = 0;
        repeat (12) begin
            if (solver_clk_en) cnt++;
            cyc();
        end
        chk("no_pulse_after_stop", cnt, 0);
        chk("stopped", running, 0);
        rd(7, d); chk("step_cnt_10", d, 32'd10);

        // Step-boundary commit at RATE=7
        wr(5, 32'd7);
        wr(4, 32'h4);
        wait_strobe("strobe_rate7");
        cyc(); cyc();
        wr(1, 32'd100);
        wr(4, 32'h1);
        wr(4, 32'h1);
        wait_strobe("strobe_commit");
        chk("ch1_held_until_strobe", ch_data[35:18], 18'd0);
        wr(1, 32'd200);
        chk("ch1_new", ch_data[35:18], 18'd100);
        rd(1, d); chk("shadow1_200", d, 32'd200);
        rd(6, d); chk("status_running_only", d, 32'd2);

        // Shrinking RATE below the current count fires on the next cycle
        wait_strobe("strobe_pre_shrink");
        repeat (5) cyc();
        wr(5, 32'd2);
        chk("rate_shrink_strobe", solver_clk_en, 1);

        // Solver reset requested together with STOP
        wr(4, 32'hA);
        chk("srst_not_running", running, 0);
        n = 0;
        while (solver_rst && n < 20) begin
            n++;
            cyc();
        end
        chk("srst_len", n, RST_CYC);
        rd(7, d); chk("step_cnt_cleared", d, 32'd0);
        kept = {18'd0, 18'd0, 18'd100, 18'h3FFFF};
        chk("ch_data_retained", ch_data, kept);

        // Reset in RUN with a commit pending
        wr(5, 32'd100);
        wr(4, 32'h4);
        wr(2, 32'd5);
        wr(4, 32'h1);
        rd(6, d); chk("status_pending_running", d, 32'd3);
        reset_reset = 1'b1; avs_read = 1'b1; avs_address = 3'd6;
        cyc();
        reset_reset = 1'b0; avs_read = 1'b0;
        chk("mrst_ch_data", ch_data, 0);
        chk("mrst_clk_en", solver_clk_en, 0);
        chk("mrst_running", running, 0);
        chk("mrst_solver_rst", solver_rst, 0);
        chk("mrst_rvld", avs_readdatavalid, 0);
        chk("mrst_rdata", avs_readdata, 0);
        rd(6, d); chk("mrst_status", d, 32'd0);
        rd(5, d); chk("mrst_rate", d, 32'(RATE_INIT));
        rd(2, d); chk("mrst_shadow2", d, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
